fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_if.sv | 13 +
 rtl/fetch_unit.sv | 196 +++++++++++++++++++
 tb/tb_fetch_unit.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Instruction RAM port between fetch_unit (master) and the instruction RAM (slave).
interface fetch_unit_if #(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 32
);
    logic               Enable;
    logic               RW_ram;
    logic [ADDR_W-1:0]  Address_out;
    logic [INSTR_W-1:0] Out;

    modport master (output Enable, output RW_ram, output Address_out, input Out);
    modport slave  (input Enable, input RW_ram, input Address_out, output Out);
endinterface

// File: rtl/fetch_unit.sv
// Three-cycle instruction fetch unit (FETCH -> WAIT -> ISSUE) with branch redirect and stall.
// Optional FETCH_HALT_EN: the all-ones instruction word parks the unit in HALT.
module fetch_unit #(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 32
) (
    input  logic               Clk,
    input  logic               Reset,
    fetch_unit_if.master       ram,
    input  logic               branch_valid,
    input  logic [ADDR_W-1:0]  branch_target,
    input  logic               stall,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instruction,
    output logic [ADDR_W-1:0]  pc,
    output logic [3:0]         Cond,
    output logic [3:0]         OpCode,
    output logic               S,
    output logic [3:0]         destination,
    output logic [3:0]         source_2,
    output logic [3:0]         source_1,
    output logic [4:0]         IV_ShiftRor,
    output logic [15:0]        IV_Mov,
    output logic [15:0]        issue_count,
    output logic               halted
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_ISSUE = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] PC_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [15:0]       CNT_ONE = 16'd1;

`ifdef FETCH_HALT_EN
    function automatic logic is_halt_word(input logic [INSTR_W-1:0] word);
        return &word;
    endfunction
`endif

    state_t             state_q,  state_d;
    logic [ADDR_W-1:0]  fpc_q,    fpc_d;
    logic [INSTR_W-1:0] ir_q,     ir_d;
    logic [ADDR_W-1:0]  ir_pc_q,  ir_pc_d;
    logic [15:0]        cnt_q,    cnt_d;
    logic               enable_q, enable_d;
    logic [ADDR_W-1:0]  addr_q,   addr_d;
    logic               valid_q,  valid_d;
    logic               halted_q, halted_d;

    // Next-state, program counter, instruction register and issue counter.
    always_comb begin
        state_d = state_q;
        fpc_d   = fpc_q;
        ir_d    = ir_q;
        ir_pc_d = ir_pc_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_FETCH: begin
                // Leaving FETCH needs a strobe actually issued; right after reset none was.
                if (branch_valid) begin
                    fpc_d   = branch_target;
                    state_d = ST_FETCH;
                end else if (enable_q) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_WAIT: begin
                if (branch_valid) begin
                    fpc_d   = branch_target;
                    state_d = ST_FETCH;
                end else begin
                    ir_d    = ram.Out;
                    ir_pc_d = fpc_q;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (branch_valid) begin
                    fpc_d   = branch_target;
                    state_d = ST_FETCH;
                end else if (stall) begin
                    state_d = ST_ISSUE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
`ifdef FETCH_HALT_EN
                    if (is_halt_word(ir_q)) begin
                        state_d = ST_HALT;
                    end else begin
                        fpc_d   = fpc_q + PC_ONE;
                        state_d = ST_FETCH;
                    end
`else
                    fpc_d   = fpc_q + PC_ONE;
                    state_d = ST_FETCH;
`endif
                end
            end
            ST_HALT: begin
`ifdef FETCH_HALT_EN
                if (branch_valid) begin
                    fpc_d   = branch_target;
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_HALT;
                end
`else
                state_d = ST_FETCH;
`endif
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // Registered output values decoded from the state being entered.
    always_comb begin
        enable_d = 1'b0;
        addr_d   = addr_q;
        valid_d  = 1'b0;
        halted_d = 1'b0;
        if (state_d == ST_FETCH) begin
            enable_d = 1'b1;
            addr_d   = fpc_d;
        end else begin
            enable_d = 1'b0;
            addr_d   = addr_q;
        end
        if (state_d == ST_ISSUE) begin
            valid_d = 1'b1;
        end else begin
            valid_d = 1'b0;
        end
`ifdef FETCH_HALT_EN
        if (state_d == ST_HALT) begin
            halted_d = 1'b1;
        end else begin
            halted_d = 1'b0;
        end
`else
        halted_d = 1'b0;
`endif
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q  <= ST_FETCH;
            fpc_q    <= {ADDR_W{1'b0}};
            ir_q     <= {INSTR_W{1'b0}};
            ir_pc_q  <= {ADDR_W{1'b0}};
            cnt_q    <= 16'h0000;
            enable_q <= 1'b0;
            addr_q   <= {ADDR_W{1'b0}};
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            fpc_q    <= fpc_d;
            ir_q     <= ir_d;
            ir_pc_q  <= ir_pc_d;
            cnt_q    <= cnt_d;
            enable_q <= enable_d;
            addr_q   <= addr_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
        end
    end

    // Strobes are also forced quiet while Reset is low, so an access in flight is dropped at once.
    assign ram.Enable      = enable_q & Reset;
    assign ram.RW_ram      = 1'b1;
    assign ram.Address_out = Reset ? addr_q : {ADDR_W{1'b0}};
    assign instr_valid     = valid_q & Reset;
    assign halted          = halted_q & Reset;

    assign instruction = ir_q;
    assign pc          = ir_pc_q;
    assign issue_count = cnt_q;

    assign Cond        = ir_q[31:28];
    assign OpCode      = ir_q[27:24];
    assign S           = ir_q[23];
    assign destination = ir_q[22:19];
    assign source_2    = ir_q[18:15];
    assign source_1    = ir_q[14:11];
    assign IV_ShiftRor = ir_q[10:6];
    assign IV_Mov      = ir_q[18:3];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit with a one-cycle-latency RAM model.
module tb_fetch_unit;

    logic        Clk;
    logic        Reset;
    logic        branch_valid;
    logic [15:0] branch_target;
    logic        stall;
    logic        instr_valid;
    logic [31:0] instruction;
    logic [15:0] pc;
    logic [3:0]  Cond, OpCode, destination, source_2, source_1;
    logic        S;
    logic [4:0]  IV_ShiftRor;
    logic [15:0] IV_Mov;
    logic [15:0] issue_count;
    logic        halted;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] mem [0:65535];

    fetch_unit_if #(.ADDR_W(16), .INSTR_W(32)) bus ();

    fetch_unit #(.ADDR_W(16), .INSTR_W(32)) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .ram           (bus),
        .branch_valid  (branch_valid),
        .branch_target (branch_target),
        .stall         (stall),
        .instr_valid   (instr_valid),
        .instruction   (instruction),
        .pc            (pc),
        .Cond          (Cond),
        .OpCode        (OpCode),
        .S             (S),
        .destination   (destination),
        .source_2      (source_2),
        .source_1      (source_1),
        .IV_ShiftRor   (IV_ShiftRor),
        .IV_Mov        (IV_Mov),
        .issue_count   (issue_count),
        .halted        (halted)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // RAM model: read data appears the cycle after Enable.
    always @(posedge Clk) begin
        if (bus.Enable) bus.Out <= mem[bus.Address_out];
    end

    typedef struct {
        logic        bv;
        logic [15:0] bt;
        logic        st;
        logic        en;
        logic [15:0] addr;
        logic        vld;
        logic [31:0] ir;
        logic [15:0] pc;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs [28];

    function automatic vec_t mk(input logic bv, input logic [15:0] bt, input logic st,
                                input logic en, input logic [15:0] addr, input logic vld,
                                input logic [31:0] ir, input logic [15:0] p, input logic [15:0] cnt);
        vec_t v;
        v.bv = bv; v.bt = bt; v.st = st; v.en = en; v.addr = addr;
        v.vld = vld; v.ir = ir; v.pc = p; v.cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic en, input logic [15:0] addr,
                             input logic vld, input logic [31:0] ir, input logic [15:0] p,
                             input logic [15:0] cnt, input logic hlt);
        chk({tag, ".Enable"},      32'(bus.Enable),      32'(en));
        chk({tag, ".Address_out"}, 32'(bus.Address_out), 32'(addr));
        chk({tag, ".instr_valid"}, 32'(instr_valid),     32'(vld));
        chk({tag, ".instruction"}, instruction,          ir);
        chk({tag, ".pc"},          32'(pc),              32'(p));
        chk({tag, ".issue_count"}, 32'(issue_count),     32'(cnt));
        chk({tag, ".halted"},      32'(halted),          32'(hlt));
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 32'h0000_0000;
        mem[16'h0000] = 32'h1111_1111;
        mem[16'h0001] = 32'h2222_2222;
        mem[16'h0002] = 32'h3333_3333;
        mem[16'h0003] = 32'hFFFF_FFFF;
        mem[16'h0040] = 32'hA5C3_9E71;
        mem[16'h0041] = 32'h4141_4141;
        mem[16'hFFFF] = 32'hFEED_FACE;

        //            bv    bt        st    en    addr      vld   ir             pc        cnt
        vecs[0]  = mk(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 32'h0000_0000, 16'h0000, 16'd0);
        vecs[1]  = mk(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 32'h0000_0000, 16'h0000, 16'd0);
        vecs[2]  = mk(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 32'h1111_1111, 16'h0000, 16'd0);
        vecs[3]  = mk(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0001, 1'b0, 32'h1111_1111, 16'h0000, 16'd1);
        vecs[4]  = mk(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0001, 1'b0, 32'h1111_1111, 16'h0000, 16'd1);
        vecs[5]  = mk(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0001, 1'b1, 32'h2222_2222, 16'h0001, 16'd1);
        vecs[6]  = mk(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b1, 32'h2222_2222, 16'h0001, 16'd1);
        vecs[7]  = mk(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b1, 32'h2222_2222, 16'h0001, 16'd1);
        vecs[8]  = mk(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b1, 32'h2222_2222, 16'h0001, 16'd1);
        vecs[9]  = mk(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b1, 32'h2222_2222, 16'h0001, 16'd1);
        vecs[10] = mk(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0002, 1'b0, 32'h2222_2222, 16'h0001, 16'd2);
        vecs[11] = mk(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0002, 1'b0, 32'h2222_2222, 16'h0001, 16'd2);
        vecs[12] = mk(1'b1, 16'h0040, 1'b0, 1'b1, 16'h0040, 1'b0, 32'h2222_2222, 16'h0001, 16'd2);
        vecs[13] = mk(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0040, 1'b0, 32'h2222_2222, 16'h0001, 16'd2);
        vecs[14] = mk(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0040, 1'b1, 32'hA5C3_9E71, 16'h0040, 16'd2);
        vecs[15] = mk(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0041, 1'b0, 32'hA5C3_9E71, 16'h0040, 16'd3);
        vecs[16] = mk(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0041, 1'b0, 32'hA5C3_9E71, 16'h0040, 16'd3);
        vecs[17] = mk(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0041, 1'b1, 32'h4141_4141, 16'h0041, 16'd3);
        vecs[18] = mk(1'b1, 16'hFFFF, 1'b1, 1'b1, 16'hFFFF, 1'b0, 32'h4141_4141, 16'h0041, 16'd3);
        vecs[19] = mk(1'b0, 16'h0000, 1'b0, 1'b0, 16'hFFFF, 1'b0, 32'h4141_4141, 16'h0041, 16'd3);
        vecs[20] = mk(1'b0, 16'h0000, 1'b0, 1'b0, 16'hFFFF, 1'b1, 32'hFEED_FACE, 16'hFFFF, 16'd3);
        vecs[21] = mk(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 32'hFEED_FACE, 16'hFFFF, 16'd4);
        vecs[22] = mk(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 32'hFEED_FACE, 16'hFFFF, 16'd4);
        vecs[23] = mk(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 32'h1111_1111, 16'h0000, 16'd4);
        vecs[24] = mk(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0001, 1'b0, 32'h1111_1111, 16'h0000, 16'd5);
        vecs[25] = mk(1'b1, 16'h0003, 1'b0, 1'b1, 16'h0003, 1'b0, 32'h1111_1111, 16'h0000, 16'd5);
        vecs[26] = mk(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0003, 1'b0, 32'h1111_1111, 16'h0000, 16'd5);
        vecs[27] = mk(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0003, 1'b1, 32'hFFFF_FFFF, 16'h0003, 16'd5);

        // Reset with branch/stall asserted: reset must win.
        Reset         = 1'b0;
        branch_valid  = 1'b1;
        branch_target = 16'h1234;
        stall         = 1'b1;
        tick();
        tick();
        chk_state("reset", 1'b0, 16'h0000, 1'b0, 32'h0000_0000, 16'h0000, 16'd0, 1'b0);
        chk("reset.RW_ram", 32'(bus.RW_ram), 32'h1);
        branch_valid  = 1'b0;
        branch_target = 16'h0000;
        stall         = 1'b0;
        Reset         = 1'b1;

        for (int i = 0; i < 28; i++) begin
            branch_valid  = vecs[i].bv;
            branch_target = vecs[i].bt;
            stall         = vecs[i].st;
            tick();
            chk_state($sformatf("v%0d", i), vecs[i].en, vecs[i].addr, vecs[i].vld,
                      vecs[i].ir, vecs[i].pc, vecs[i].cnt, 1'b0);
            if (i == 14) begin
                chk("field.Cond",        32'(Cond),        32'h0000_000A);
                chk("field.OpCode",      32'(OpCode),      32'h0000_0005);
                chk("field.S",           32'(S),           32'h0000_0001);
                chk("field.destination", 32'(destination), 32'h0000_0008);
                chk("field.source_2",    32'(source_2),    32'h0000_0007);
                chk("field.source_1",    32'(source_1),    32'h0000_0003);
                chk("field.IV_ShiftRor", 32'(IV_ShiftRor), 32'h0000_0019);
                chk("field.IV_Mov",      32'(IV_Mov),      32'h0000_73CE);
            end
        end
        branch_valid  = 1'b0;
        branch_target = 16'h0000;
        stall         = 1'b0;

`ifdef FETCH_HALT_EN
        // All-ones word parks the unit; a branch to 0 restarts it.
        tick();
        chk_state("halt0", 1'b0, 16'h0003, 1'b0, 32'hFFFF_FFFF, 16'h0003, 16'd6, 1'b1);
        tick();
        chk_state("halt1", 1'b0, 16'h0003, 1'b0, 32'hFFFF_FFFF, 16'h0003, 16'd6, 1'b1);
        branch_valid = 1'b1;
        tick();
        branch_valid = 1'b0;
        chk_state("unhalt", 1'b1, 16'h0000, 1'b0, 32'hFFFF_FFFF, 16'h0003, 16'd6, 1'b0);
        tick();
        chk_state("refetch.wait", 1'b0, 16'h0000, 1'b0, 32'hFFFF_FFFF, 16'h0003, 16'd6, 1'b0);
        tick();
        chk_state("refetch.issue", 1'b0, 16'h0000, 1'b1, 32'h1111_1111, 16'h0000, 16'd6, 1'b0);
        tick();
        chk_state("refetch.next", 1'b1, 16'h0001, 1'b0, 32'h1111_1111, 16'h0000, 16'd7, 1'b0);
        tick();
        chk_state("prereset.wait", 1'b0, 16'h0001, 1'b0, 32'h1111_1111, 16'h0000, 16'd7, 1'b0);
`else
        // All-ones word is ordinary: fetch continues at address 4.
        tick();
        chk_state("nohalt.fetch", 1'b1, 16'h0004, 1'b0, 32'hFFFF_FFFF, 16'h0003, 16'd6, 1'b0);
        tick();
        chk_state("prereset.wait", 1'b0, 16'h0004, 1'b0, 32'hFFFF_FFFF, 16'h0003, 16'd6, 1'b0);
`endif

        // Reset asserted while in WAIT: access aborted, restart from address 0.
        Reset = 1'b0;
        #1;
        chk("inreset.Enable",      32'(bus.Enable),      32'h0);
        chk("inreset.Address_out", 32'(bus.Address_out), 32'h0);
        tick();
        chk_state("wreset", 1'b0, 16'h0000, 1'b0, 32'h0000_0000, 16'h0000, 16'd0, 1'b0);
        Reset = 1'b1;
        tick();
        chk_state("post.fetch", 1'b1, 16'h0000, 1'b0, 32'h0000_0000, 16'h0000, 16'd0, 1'b0);
        tick();
        chk_state("post.wait", 1'b0, 16'h0000, 1'b0, 32'h0000_0000, 16'h0000, 16'd0, 1'b0);
        tick();
        chk_state("post.issue", 1'b0, 16'h0000, 1'b1, 32'h1111_1111, 16'h0000, 16'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
